// File: rtl/counter_sweep_ctrl_if.sv
// Request/status bundle for counter_sweep_ctrl: master drives the sweep request, slave reports progress.
// Purely combinational wiring; no flow control beyond the busy/done status.
interface counter_sweep_ctrl_if #(
  parameter int W = 8
);
  logic         start;
  logic         abort;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic [7:0]   n_sweeps;
  logic         pingpong;
  logic         busy;
  logic         done;
  logic         err;
  logic         dir;
  logic [W-1:0] c_out;
  logic [7:0]   sweep_cnt;

  modport master (
    output start, abort, lo, hi, n_sweeps, pingpong,
    input  busy, done, err, dir, c_out, sweep_cnt
  );

  modport slave (
    input  start, abort, lo, hi, n_sweeps, pingpong,
    output busy, done, err, dir, c_out, sweep_cnt
  );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// Bounded up/down counter sweep sequencer; registered outputs, first value one cycle after start, start ignored while busy.
// Optional endpoint dwell enabled by defining SWEEP_DWELL_EN (length set by DWELL).
module counter_sweep_ctrl #(
  parameter int W     = 8,
  parameter int DWELL = 4
) (
  input logic                  i_clk,
  input logic                  i_resetn,
  counter_sweep_ctrl_if.slave  bus
);

  if (DWELL < 1) begin : g_bad_dwell
    $error("counter_sweep_ctrl: DWELL must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
`ifdef SWEEP_DWELL_EN
    S_DWELL,
`endif
    S_DONE
  } state_t;

  state_t       r_state, w_state_nxt;
  logic [W-1:0] r_c, w_c_nxt;
  logic         r_dir, w_dir_nxt;
  logic [7:0]   r_sweep, w_sweep_nxt;
  logic [W-1:0] r_lo, w_lo_nxt;
  logic [W-1:0] r_hi, w_hi_nxt;
  logic [7:0]   r_n, w_n_nxt;
  logic         r_pp, w_pp_nxt;
  logic         r_busy, r_done, r_err, w_err_nxt;

`ifdef SWEEP_DWELL_EN
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  logic [DW_W-1:0] r_dw, w_dw_nxt;
`endif

  logic [7:0]   w_sweep_inc;
  logic         w_last;
  logic         w_same;
  // Step taken after a completed up-sweep / down-sweep (wrap or reversal)
  state_t       w_up_state, w_dn_state;
  logic [W-1:0] w_up_c, w_dn_c;
  logic         w_up_dir;

  assign w_sweep_inc = r_sweep + 8'd1;
  assign w_last      = (w_sweep_inc == r_n);
  assign w_same      = (r_lo == r_hi);

  always_comb begin
    w_up_state = S_UP;
    w_up_c     = r_lo;
    w_up_dir   = 1'b1;
    if (r_pp) begin
      w_up_state = S_DOWN;
      w_up_c     = w_same ? r_hi : r_hi - W'(1);
      w_up_dir   = 1'b0;
    end
    w_dn_state = S_UP;
    w_dn_c     = w_same ? r_lo : r_lo + W'(1);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_c_nxt     = r_c;
    w_dir_nxt   = r_dir;
    w_sweep_nxt = r_sweep;
    w_lo_nxt    = r_lo;
    w_hi_nxt    = r_hi;
    w_n_nxt     = r_n;
    w_pp_nxt    = r_pp;
    w_err_nxt   = 1'b0;
`ifdef SWEEP_DWELL_EN
    w_dw_nxt    = r_dw;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if ((bus.lo > bus.hi) || (bus.n_sweeps == 8'd0)) begin
            w_state_nxt = S_DONE;
            w_err_nxt   = 1'b1;
          end else begin
            w_lo_nxt    = bus.lo;
            w_hi_nxt    = bus.hi;
            w_n_nxt     = bus.n_sweeps;
            w_pp_nxt    = bus.pingpong;
            w_sweep_nxt = 8'd0;
            w_c_nxt     = bus.lo;
            w_dir_nxt   = 1'b1;
            w_state_nxt = S_UP;
          end
        end
      end
      S_UP: begin
        if (bus.abort) begin
          w_state_nxt = S_DONE;
        end else if (r_c != r_hi) begin
          w_c_nxt = r_c + W'(1);
        end else begin
          w_sweep_nxt = w_sweep_inc;
          if (w_last) begin
            w_state_nxt = S_DONE;
          end else begin
`ifdef SWEEP_DWELL_EN
            w_state_nxt = S_DWELL;
            w_dw_nxt    = DW_W'(DWELL - 1);
`else
            w_state_nxt = w_up_state;
            w_c_nxt     = w_up_c;
            w_dir_nxt   = w_up_dir;
`endif
          end
        end
      end
      S_DOWN: begin
        if (bus.abort) begin
          w_state_nxt = S_DONE;
        end else if (r_c != r_lo) begin
          w_c_nxt = r_c - W'(1);
        end else begin
          w_sweep_nxt = w_sweep_inc;
          if (w_last) begin
            w_state_nxt = S_DONE;
          end else begin
`ifdef SWEEP_DWELL_EN
            w_state_nxt = S_DWELL;
            w_dw_nxt    = DW_W'(DWELL - 1);
`else
            w_state_nxt = w_dn_state;
            w_c_nxt     = w_dn_c;
            w_dir_nxt   = 1'b1;
`endif
          end
        end
      end
`ifdef SWEEP_DWELL_EN
      // dir is untouched while dwelling, so it records which endpoint we sit on
      S_DWELL: begin
        if (bus.abort) begin
          w_state_nxt = S_DONE;
        end else if (r_dw != '0) begin
          w_dw_nxt = r_dw - DW_W'(1);
        end else if (r_dir) begin
          w_state_nxt = w_up_state;
          w_c_nxt     = w_up_c;
          w_dir_nxt   = w_up_dir;
        end else begin
          w_state_nxt = w_dn_state;
          w_c_nxt     = w_dn_c;
          w_dir_nxt   = 1'b1;
        end
      end
`endif
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state <= S_IDLE;
      r_c     <= '0;
      r_dir   <= 1'b0;
      r_sweep <= 8'd0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_n     <= 8'd0;
      r_pp    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef SWEEP_DWELL_EN
      r_dw    <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
      r_dir   <= w_dir_nxt;
      r_sweep <= w_sweep_nxt;
      r_lo    <= w_lo_nxt;
      r_hi    <= w_hi_nxt;
      r_n     <= w_n_nxt;
      r_pp    <= w_pp_nxt;
      r_busy  <= (w_state_nxt == S_UP) || (w_state_nxt == S_DOWN)
`ifdef SWEEP_DWELL_EN
                 || (w_state_nxt == S_DWELL)
`endif
                 ;
      r_done  <= (w_state_nxt == S_DONE);
      r_err   <= w_err_nxt;
`ifdef SWEEP_DWELL_EN
      r_dw    <= w_dw_nxt;
`endif
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.dir       = r_dir;
  assign bus.c_out     = r_c;
  assign bus.sweep_cnt = r_sweep;

endmodule
